instruction_fetch_queue: RTL and testbench

Decoupled instruction fetch front end for the LEGv8 core. Owns the fetch PC, issues one-at-a-time word requests to instruction memory over a valid/ready handshake, buffers returned instructions with their PCs in a small in-order queue, and presents them to the decode/control stage over a second valid/ready handshake. A branch redirect flushes the queue, cancels any in-flight fetch and restarts fetching at the new target.

---
 rtl/instruction_fetch_queue_if.sv | 33 +++
 rtl/instruction_fetch_queue.sv | 115 +++++++++++
 tb/tb_instruction_fetch_queue.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/instruction_fetch_queue_if.sv
// Fetch-queue boundary: instruction-memory request/response, branch redirect and decode-side handshake.
interface instruction_fetch_queue_if #(
  parameter int DEPTH = 4
);
  logic                         imem_req_valid;
  logic [63:0]                  imem_req_addr;
  logic                         imem_req_ready;
  logic                         imem_resp_valid;
  logic [31:0]                  imem_resp_data;
  logic                         redirect_valid;
  logic [63:0]                  redirect_pc;
  logic                         inst_valid;
  logic [31:0]                  inst_data;
  logic [63:0]                  inst_pc;
  logic                         inst_ready;
  logic [$clog2(DEPTH+1)-1:0]   queue_count;

  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready, imem_resp_valid, imem_resp_data,
    input  redirect_valid, redirect_pc,
    output inst_valid, inst_data, inst_pc, queue_count,
    input  inst_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready, imem_resp_valid, imem_resp_data,
    output redirect_valid, redirect_pc,
    input  inst_valid, inst_data, inst_pc, queue_count,
    output inst_ready
  );
endinterface

// File: rtl/instruction_fetch_queue.sv
// Fetch PC + one-outstanding imem fetch + in-order instruction queue; 1-cycle response-to-head latency,
// or zero with IFQ_BYPASS_EN; requests stall while the queue is full, redirect flushes and refetches.
module instruction_fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [63:0] RESET_PC = 64'd0
) (
  input  logic                        clk,
  input  logic                        reset_n,
  instruction_fetch_queue_if.master   ifq
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DROP} state_t;

  state_t             state, stateNext;
  logic [63:0]        fetchPc;
  logic [63:0]        issuedPc;
  logic [63:0]        entryPc   [DEPTH];
  logic [31:0]        entryData [DEPTH];
  logic [PTR_W-1:0]   wrPtr, rdPtr;
  logic [CNT_W-1:0]   count;

  logic reqFire;
  logic respAccept;
  logic bypassTaken;
  logic push;
  logic pop;

  assign ifq.imem_req_valid = (state == REQ) && (count < CNT_W'(DEPTH));
  assign ifq.imem_req_addr  = {fetchPc[63:2], 2'b00};
  assign ifq.queue_count    = count;
  assign reqFire            = ifq.imem_req_valid && ifq.imem_req_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= stateNext;
  end

  // A request accepted in a redirect cycle is still outstanding, so its response must be dropped.
  always_comb begin
    stateNext  = state;
    respAccept = 1'b0;
    unique case (state)
      IDLE: stateNext = REQ;
      REQ: begin
        if (ifq.redirect_valid) stateNext = reqFire ? DROP : REQ;
        else if (reqFire)       stateNext = WAIT;
      end
      WAIT: begin
        if (ifq.redirect_valid) begin
          stateNext = ifq.imem_resp_valid ? REQ : DROP;
        end else if (ifq.imem_resp_valid) begin
          stateNext  = REQ;
          respAccept = 1'b1;
        end
      end
      DROP: if (ifq.imem_resp_valid) stateNext = REQ;
      default: stateNext = IDLE;
    endcase
  end

`ifdef IFQ_BYPASS_EN
  logic bypassVld;
  assign bypassVld      = (count == '0) && respAccept;
  assign bypassTaken    = bypassVld && ifq.inst_ready;
  assign ifq.inst_valid = (count != '0) || bypassVld;
  assign ifq.inst_data  = (count != '0) ? entryData[rdPtr] : ifq.imem_resp_data;
  assign ifq.inst_pc    = (count != '0) ? entryPc[rdPtr]   : issuedPc;
`else
  assign bypassTaken    = 1'b0;
  assign ifq.inst_valid = (count != '0);
  assign ifq.inst_data  = entryData[rdPtr];
  assign ifq.inst_pc    = entryPc[rdPtr];
`endif

  assign push = respAccept && !bypassTaken;
  assign pop  = (count != '0) && ifq.inst_ready && !ifq.redirect_valid;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fetchPc  <= RESET_PC;
      issuedPc <= '0;
    end else begin
      if (reqFire) issuedPc <= fetchPc;
      if (ifq.redirect_valid) fetchPc <= {ifq.redirect_pc[63:2], 2'b00};
      else if (reqFire)       fetchPc <= fetchPc + 64'd4;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        entryPc[i]   <= '0;
        entryData[i] <= '0;
      end
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else if (ifq.redirect_valid) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (push) begin
        entryPc[wrPtr]   <= issuedPc;
        entryData[wrPtr] <= ifq.imem_resp_data;
        wrPtr            <= wrPtr + PTR_W'(1);
      end
      if (pop) rdPtr <= rdPtr + PTR_W'(1);
      if (push && !pop)      count <= count + CNT_W'(1);
      else if (!push && pop) count <= count - CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_instruction_fetch_queue.sv
module tb_instruction_fetch_queue;
  localparam int          DEPTH    = 4;
  localparam logic [63:0] RESET_PC = 64'd0;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] data;
  } ent_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  instruction_fetch_queue_if #(.DEPTH(DEPTH)) ifq ();

  instruction_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .ifq     (ifq)
  );

  int checks = 0;
  int failures = 0;

  // Reference model: the stream of instructions the decoder should see, plus the single memory transaction.
  ent_t        expQ[$];
  logic [63:0] expAddr = RESET_PC;
  bit          outstanding = 0;
  bit          killed = 0;
  logic [63:0] pendPc = '0;
  logic [31:0] pendData = '0;
  bit          running = 0;
  bit          bypassExpect = 0;
  int          pops = 0;
  logic [63:0] lastPopPc = '0;
  logic [63:0] popLog[$];
  int          maxCnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Head/occupancy view of the queue, sampled before this cycle's inputs take effect.
  always begin
    @(negedge clk);
    #1;
    if (running && reset_n) begin
      check("queue_count", 64'(ifq.queue_count), 64'(expQ.size()));
      if (int'(ifq.queue_count) > maxCnt) maxCnt = int'(ifq.queue_count);
      if (expQ.size() != 0) begin
        check("head_valid", 64'(ifq.inst_valid), 64'd1);
        check("head_pc", ifq.inst_pc, expQ[0].pc);
        check("head_data", 64'(ifq.inst_data), 64'(expQ[0].data));
      end
`ifndef IFQ_BYPASS_EN
      else check("empty_valid", 64'(ifq.inst_valid), 64'd0);
`endif
      if (outstanding) check("one_outstanding", 64'(ifq.imem_req_valid), 64'd0);
      if (int'(ifq.queue_count) == DEPTH) check("full_no_req", 64'(ifq.imem_req_valid), 64'd0);
    end
  end

  // Model: turns memory/redirect events of this cycle into expected instructions.
  always begin
    @(negedge clk);
    #2;
    bypassExpect = 0;
    if (running && reset_n) begin
      if (ifq.imem_resp_valid && outstanding) begin
        if (!killed && !ifq.redirect_valid) begin
          bypassExpect = (expQ.size() == 0);
          expQ.push_back('{pc: pendPc, data: pendData});
        end
        outstanding = 0;
      end
      if (ifq.imem_req_valid && ifq.imem_req_ready) begin
        check("req_addr", ifq.imem_req_addr, expAddr);
        pendPc      = expAddr;
        pendData    = $urandom;
        expAddr     = expAddr + 64'd4;
        outstanding = 1;
        killed      = 0;
      end
      if (ifq.redirect_valid) begin
        expQ.delete();
        expAddr = {ifq.redirect_pc[63:2], 2'b00};
        killed  = 1;
      end
    end
  end

  // Monitor: pops the scoreboard whenever decode consumes an instruction.
  always begin
    @(negedge clk);
    #3;
    if (running && reset_n) begin
`ifdef IFQ_BYPASS_EN
      if (bypassExpect) check("bypass_valid", 64'(ifq.inst_valid), 64'd1);
`endif
      if (ifq.inst_valid && ifq.inst_ready && !ifq.redirect_valid) begin
        if (expQ.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_inst: got pc %h expected no instruction", ifq.inst_pc);
        end else begin
          ent_t e;
          e = expQ.pop_front();
          check("inst_pc", ifq.inst_pc, e.pc);
          check("inst_data", 64'(ifq.inst_data), 64'(e.data));
        end
        pops++;
        lastPopPc = ifq.inst_pc;
        popLog.push_back(ifq.inst_pc);
      end
    end
  end

  // mode 0: random memory timing, 1: ready + immediate response, 2: ready but response withheld
  task automatic cycle(input int mode, input bit rdy, input bit rdv, input logic [63:0] rpc);
    @(negedge clk);
    ifq.imem_req_ready  = (mode == 0) ? 1'($urandom_range(0, 1)) : 1'b1;
    ifq.imem_resp_valid = outstanding && (mode == 1 || (mode == 0 && $urandom_range(0, 2) != 0));
    ifq.imem_resp_data  = pendData;
    ifq.inst_ready      = rdy;
    ifq.redirect_valid  = rdv;
    ifq.redirect_pc     = rpc;
  endtask

  task automatic checkResetValues();
    check("rst_req_valid", 64'(ifq.imem_req_valid), 64'd0);
    check("rst_req_addr", ifq.imem_req_addr, RESET_PC);
    check("rst_inst_valid", 64'(ifq.inst_valid), 64'd0);
    check("rst_inst_data", 64'(ifq.inst_data), 64'd0);
    check("rst_inst_pc", ifq.inst_pc, 64'd0);
    check("rst_queue_count", 64'(ifq.queue_count), 64'd0);
  endtask

  task automatic clearModel();
    expQ.delete();
    expAddr     = RESET_PC;
    outstanding = 0;
    killed      = 0;
  endtask

  task automatic waitOutstanding(input string name);
    bit seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      cycle(2, 1'b1, 1'b0, 64'd0);
      #3;
      seen = outstanding;
    end
    check(name, 64'(seen), 64'd1);
  endtask

  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    int startPops;
    ifq.imem_req_ready  = 1'b0;
    ifq.imem_resp_valid = 1'b0;
    ifq.imem_resp_data  = '0;
    ifq.redirect_valid  = 1'b0;
    ifq.redirect_pc     = '0;
    ifq.inst_ready      = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checkResetValues();
    @(negedge clk);
    reset_n = 1'b1;
    running = 1;

    // Single-cycle memory, decode always ready.
    for (int i = 0; i < 60 && pops < 4; i++) cycle(1, 1'b1, 1'b0, 64'd0);
    #4;
    check("phase1_pops", 64'(pops >= 4), 64'd1);
    for (int i = 0; i < 4; i++)
      check("phase1_order", (popLog.size() > i) ? popLog[i] : 64'hDEAD, 64'(4 * i));
    check("phase1_count_le1", 64'(maxCnt <= 1), 64'd1);

    // Decode stalled: queue fills and fetch stops.
    repeat (20) cycle(1, 1'b0, 1'b0, 64'd0);
    #1;
    check("stall_full", 64'(ifq.queue_count), 64'(DEPTH));
    check("stall_no_req", 64'(ifq.imem_req_valid), 64'd0);
    startPops = pops;
    repeat (20) cycle(1, 1'b1, 1'b0, 64'd0);
    #4;
    check("drain_pops", 64'(pops - startPops >= DEPTH), 64'd1);

    // Redirect while waiting on memory, with unaligned target.
    waitOutstanding("wait_before_redirect");
    cycle(2, 1'b1, 1'b1, 64'h103);
    cycle(2, 1'b1, 1'b0, 64'd0);
    #1;
    check("redirect_aligned_addr", ifq.imem_req_addr, 64'h100);
    check("redirect_flush", 64'(ifq.queue_count), 64'd0);
    startPops = pops;
    for (int i = 0; i < 20 && pops == startPops; i++) cycle(1, 1'b1, 1'b0, 64'd0);
    #4;
    check("redirect_first_pc", lastPopPc, 64'h100);

    // Redirect coincident with the response: no DROP, refetch next cycle.
    waitOutstanding("wait_before_coincident");
    cycle(1, 1'b1, 1'b1, 64'h200);
    cycle(1, 1'b1, 1'b0, 64'd0);
    #1;
    check("coincident_req_valid", 64'(ifq.imem_req_valid), 64'd1);
    check("coincident_req_addr", ifq.imem_req_addr, 64'h200);

    // Fetch PC wraps past the top of the address space.
    cycle(1, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC);
    startPops = pops;
    for (int i = 0; i < 30 && pops < startPops + 2; i++) cycle(1, 1'b1, 1'b0, 64'd0);
    #4;
    check("wrap_second_pc", (popLog.size() >= 2) ? popLog[popLog.size() - 1 - (pops - startPops - 2)] : 64'hDEAD, 64'd0);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      logic [63:0] tgt;
      tgt = ($urandom_range(0, 3) == 0) ? (64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 15)))
                                        : {32'($urandom), 32'($urandom)};
      cycle(0, $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0, tgt);
    end

    // Asynchronous reset in mid-transfer, then a stray response while idle.
    @(negedge clk);
    running = 0;
    #2;
    reset_n = 1'b0;
    #1;
    checkResetValues();
    clearModel();
    @(negedge clk);
    reset_n             = 1'b1;
    ifq.imem_resp_valid = 1'b1;
    ifq.redirect_valid  = 1'b0;
    ifq.inst_ready      = 1'b1;
    running             = 1;
    startPops = pops;
    for (int i = 0; i < 40 && pops < startPops + 3; i++) cycle(1, 1'b1, 1'b0, 64'd0);
    #4;
    check("post_reset_progress", 64'(pops - startPops >= 3), 64'd1);
    check("post_reset_last_pc", lastPopPc, RESET_PC + 64'd8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
